// File: rtl/rsa_ctrl_pkg.sv
// Shared types and default parameter values for the rsa_unit run controller.
package rsa_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET    = 3'd0,
    IDLE     = 3'd1,
    EN       = 3'd2,
    RST_REL  = 3'd3,
    WAIT_EOC = 3'd4,
    EOC      = 3'd5,
    TMO      = 3'd6,
    ABORT    = 3'd7
  } state_t;

  localparam int DEF_N_UNITS = 2;
  localparam int DEF_RST_DLY = 1;
  localparam int DEF_TMO_W   = 16;

  // Width of the reset-release delay counter; covers RST_DLY up to 15.
  localparam int DLY_W = 4;

endpackage

// File: rtl/rsa_ctrl_timer.sv
// Clearable, saturating up-counter with ena gating and a terminal-match flag.
module rsa_ctrl_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         ena,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic         match
);

  logic [W-1:0] cnt;

  // Count while inc is high, hold at all-ones, clear takes priority; frozen when ena is low.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (ena) begin
      if (clr) begin
        cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
        cnt <= cnt + W'(1);
      end
    end
  end

  assign match = (cnt == term);

endmodule

// File: rtl/rsa_multi_ctrl.sv
// Run controller: sequences enable and reset release to a selected subset of
// rsa_unit instances, gathers their end-of-conversion and flags done/timeout.
module rsa_multi_ctrl
  import rsa_ctrl_pkg::*;
#(
  parameter int N_UNITS = DEF_N_UNITS,
  parameter int RST_DLY = DEF_RST_DLY,
  parameter int TMO_W   = DEF_TMO_W
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               ena,
  input  logic               gpio_start,
  input  logic               spi_start,
  input  logic               gpio_stop,
  input  logic               spi_stop,
  input  logic [N_UNITS-1:0] run_mask,
  input  logic [TMO_W-1:0]   tmo_limit,
  input  logic [N_UNITS-1:0] eoc_rsa_unit,
  output logic [N_UNITS-1:0] en_rsa,
  output logic [N_UNITS-1:0] rst_rsa,
  output logic               busy,
  output logic               eoc,
  output logic               tmo_err,
  output logic [N_UNITS-1:0] done_mask
);

  localparam logic [DLY_W-1:0] DLY_TERM = DLY_W'(RST_DLY - 1);

  state_t             state_q, state_d;
  logic [N_UNITS-1:0] mask_q;
  logic [N_UNITS-1:0] done_q;
  logic [N_UNITS-1:0] done_next;
  logic               tmo_err_q;
  logic               start_c;
  logic               stop_c;
  logic               start_ok;
  logic               dly_match;
  logic               tmo_match;

  // Either source may start a run; stopping needs both sources to agree.
  assign start_c   = gpio_start | spi_start;
  assign stop_c    = gpio_stop & spi_stop;
  assign start_ok  = (state_q == IDLE) && start_c && (run_mask != '0);
  assign done_next = done_q | (eoc_rsa_unit & mask_q);

  rsa_ctrl_timer #(.W(DLY_W)) u_dly (
    .clk   (clk),
    .rstb  (rstb),
    .ena   (ena),
    .clr   (state_q != EN),
    .inc   (state_q == EN),
    .term  (DLY_TERM),
    .match (dly_match)
  );

  // The timeout count starts from zero on the first WAIT_EOC cycle.
  rsa_ctrl_timer #(.W(TMO_W)) u_tmo (
    .clk   (clk),
    .rstb  (rstb),
    .ena   (ena),
    .clr   (state_q == RST_REL),
    .inc   (state_q == WAIT_EOC),
    .term  (tmo_limit - TMO_W'(1)),
    .match (tmo_match)
  );

  // State, latched mask, sticky done bits and timeout flag advance only with ena.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= RESET;
      mask_q    <= '0;
      done_q    <= '0;
      tmo_err_q <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      if (start_ok) begin
        mask_q    <= run_mask;
        done_q    <= '0;
        tmo_err_q <= 1'b0;
      end
      if (state_q == WAIT_EOC) begin
        done_q <= done_next;
      end
      if (state_d == TMO) begin
        tmo_err_q <= 1'b1;
      end
    end
  end

  // Next-state decode and per-state unit enable / reset-release outputs.
  always_comb begin
    state_d = state_q;
    en_rsa  = '0;
    rst_rsa = '0;
    eoc     = 1'b0;
    busy    = 1'b1;
    case (state_q)
      RESET: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
      IDLE: begin
        busy = 1'b0;
        if (start_ok) state_d = EN;
      end
      EN: begin
        en_rsa = mask_q;
        if (stop_c)         state_d = ABORT;
        else if (dly_match) state_d = RST_REL;
      end
      RST_REL: begin
        en_rsa  = mask_q;
        rst_rsa = mask_q;
        state_d = stop_c ? ABORT : WAIT_EOC;
      end
      WAIT_EOC: begin
        en_rsa  = mask_q;
        rst_rsa = mask_q;
        if (stop_c)                                   state_d = ABORT;
        else if (done_next == mask_q)                 state_d = EOC;
        else if ((tmo_limit != '0) && tmo_match)      state_d = TMO;
      end
      EOC: begin
        en_rsa  = mask_q;
        rst_rsa = mask_q;
        eoc     = 1'b1;
        state_d = IDLE;
      end
      TMO: begin
        en_rsa  = mask_q;
        state_d = IDLE;
      end
      ABORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = RESET;
      end
    endcase
  end

  assign tmo_err   = tmo_err_q;
  assign done_mask = done_q;

endmodule

// File: tb/tb_rsa_multi_ctrl.sv
// Directed bench for rsa_multi_ctrl: a default instance (RST_DLY=1) and a
// second instance with RST_DLY=3 for the enable-freeze scenario.
module tb_rsa_multi_ctrl;
  import rsa_ctrl_pkg::*;

  logic        clk;
  logic        rstb;
  logic        ena;
  logic        gpio_start, spi_start, gpio_stop, spi_stop;
  logic [1:0]  run_mask;
  logic [15:0] tmo_limit;
  logic [1:0]  eoc_rsa_unit;

  logic [1:0]  en_rsa, rst_rsa, done_mask;
  logic        busy, eoc, tmo_err;
  logic [1:0]  en_rsa3, rst_rsa3, done_mask3;
  logic        busy3, eoc3, tmo_err3;

  int n_cmp = 0;
  int n_err = 0;

  rsa_multi_ctrl #(.N_UNITS(2), .RST_DLY(1), .TMO_W(16)) dut (
    .clk(clk), .rstb(rstb), .ena(ena),
    .gpio_start(gpio_start), .spi_start(spi_start),
    .gpio_stop(gpio_stop), .spi_stop(spi_stop),
    .run_mask(run_mask), .tmo_limit(tmo_limit), .eoc_rsa_unit(eoc_rsa_unit),
    .en_rsa(en_rsa), .rst_rsa(rst_rsa), .busy(busy), .eoc(eoc),
    .tmo_err(tmo_err), .done_mask(done_mask)
  );

  rsa_multi_ctrl #(.N_UNITS(2), .RST_DLY(3), .TMO_W(16)) dut3 (
    .clk(clk), .rstb(rstb), .ena(ena),
    .gpio_start(gpio_start), .spi_start(spi_start),
    .gpio_stop(gpio_stop), .spi_stop(spi_stop),
    .run_mask(run_mask), .tmo_limit(tmo_limit), .eoc_rsa_unit(eoc_rsa_unit),
    .en_rsa(en_rsa3), .rst_rsa(rst_rsa3), .busy(busy3), .eoc(eoc3),
    .tmo_err(tmo_err3), .done_mask(done_mask3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstb = 1'b0; ena = 1'b1;
    gpio_start = 0; spi_start = 0; gpio_stop = 0; spi_stop = 0;
    run_mask = 2'b00; tmo_limit = 16'd0; eoc_rsa_unit = 2'b00;

    // Reset state
    #2;
    chk("rst_en",    32'(en_rsa), 32'h0);
    chk("rst_rel",   32'(rst_rsa), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_eoc",   32'(eoc), 32'h0);
    chk("rst_tmo",   32'(tmo_err), 32'h0);
    chk("rst_done",  32'(done_mask), 32'h0);
    chk("rst_state", 32'(dut.state_q), 32'(RESET));
    tick(2);
    rstb = 1'b1;
    tick(1);
    chk("post_rst_idle", 32'(dut.state_q), 32'(IDLE));

    // Normal run, both units
    run_mask = 2'b11; tmo_limit = 16'd0; gpio_start = 1'b1;
    tick(1);
    gpio_start = 1'b0;
    chk("n_en_p1",   32'(en_rsa), 32'h3);
    chk("n_rel_p1",  32'(rst_rsa), 32'h0);
    chk("n_busy_p1", 32'(busy), 32'h1);
    tick(1);
    chk("n_en_p2",  32'(en_rsa), 32'h3);
    chk("n_rel_p2", 32'(rst_rsa), 32'h3);
    tick(2);
    eoc_rsa_unit = 2'b01;
    tick(1);
    eoc_rsa_unit = 2'b00;
    chk("n_done01", 32'(done_mask), 32'h1);
    chk("n_noeoc",  32'(eoc), 32'h0);
    chk("n_wait",   32'(dut.state_q), 32'(WAIT_EOC));
    tick(3);
    eoc_rsa_unit = 2'b10;
    tick(1);
    eoc_rsa_unit = 2'b00;
    chk("n_eoc",    32'(eoc), 32'h1);
    chk("n_done11", 32'(done_mask), 32'h3);
    chk("n_eoc_en", 32'(en_rsa), 32'h3);
    tick(1);
    chk("n_eoc_pulse", 32'(eoc), 32'h0);
    chk("n_idle_busy", 32'(busy), 32'h0);
    chk("n_idle_en",   32'(en_rsa), 32'h0);
    chk("n_done_stky", 32'(done_mask), 32'h3);

    // Stop agreement, out-of-mask eoc, start while busy
    run_mask = 2'b01; spi_start = 1'b1;
    tick(1);
    spi_start = 1'b0;
    chk("s_done_clr", 32'(done_mask), 32'h0);
    tick(2);
    gpio_stop = 1'b1; spi_stop = 1'b0; eoc_rsa_unit = 2'b10;
    run_mask = 2'b11; spi_start = 1'b1;
    tick(1);
    chk("s_onestop_busy", 32'(busy), 32'h1);
    chk("s_onestop_en",   32'(en_rsa), 32'h1);
    chk("s_mask_bit1",    32'(done_mask), 32'h0);
    tick(1);
    chk("s_busystart_en", 32'(en_rsa), 32'h1);
    chk("s_state_wait",   32'(dut.state_q), 32'(WAIT_EOC));
    spi_start = 1'b0; eoc_rsa_unit = 2'b00; spi_stop = 1'b1;
    tick(1);
    gpio_stop = 1'b0; spi_stop = 1'b0;
    chk("s_abort_st",  32'(dut.state_q), 32'(ABORT));
    chk("s_abort_en",  32'(en_rsa), 32'h0);
    chk("s_abort_rel", 32'(rst_rsa), 32'h0);
    chk("s_abort_eoc", 32'(eoc), 32'h0);
    tick(1);
    chk("s_idle_busy", 32'(busy), 32'h0);
    chk("s_idle_eoc",  32'(eoc), 32'h0);

    // Start with empty mask is ignored
    run_mask = 2'b00; gpio_start = 1'b1;
    tick(1);
    gpio_start = 1'b0;
    chk("z_state", 32'(dut.state_q), 32'(IDLE));
    chk("z_busy",  32'(busy), 32'h0);

    // Timeout after four WAIT_EOC cycles
    run_mask = 2'b01; tmo_limit = 16'd4; gpio_start = 1'b1;
    tick(1);
    gpio_start = 1'b0;
    tick(2);
    tick(3);
    chk("t_w3_state", 32'(dut.state_q), 32'(WAIT_EOC));
    chk("t_w3_tmo",   32'(tmo_err), 32'h0);
    tick(1);
    chk("t_state", 32'(dut.state_q), 32'(TMO));
    chk("t_en",    32'(en_rsa), 32'h1);
    chk("t_rel",   32'(rst_rsa), 32'h0);
    chk("t_err",   32'(tmo_err), 32'h1);
    tick(3);
    chk("t_sticky", 32'(tmo_err), 32'h1);
    chk("t_idle",   32'(busy), 32'h0);
    spi_start = 1'b1;
    tick(1);
    spi_start = 1'b0;
    chk("t_clr", 32'(tmo_err), 32'h0);

    // Last eoc collides with timeout: eoc wins
    tick(2);
    tick(3);
    eoc_rsa_unit = 2'b01;
    tick(1);
    eoc_rsa_unit = 2'b00;
    chk("c_eoc", 32'(eoc), 32'h1);
    chk("c_tmo", 32'(tmo_err), 32'h0);
    tick(1);
    chk("c_idle", 32'(busy), 32'h0);

    // Bring the RST_DLY=3 instance back to IDLE
    gpio_stop = 1'b1; spi_stop = 1'b1;
    tick(1);
    gpio_stop = 1'b0; spi_stop = 1'b0;
    tick(2);
    chk("f_pre_idle", 32'(busy3), 32'h0);

    // Enable freeze during EN with RST_DLY=3
    run_mask = 2'b11; tmo_limit = 16'd0; gpio_start = 1'b1;
    tick(1);
    gpio_start = 1'b0;
    chk("f_en", 32'(en_rsa3), 32'h3);
    tick(1);
    ena = 1'b0;
    tick(10);
    chk("f_frz_state", 32'(dut3.state_q), 32'(EN));
    chk("f_frz_en",    32'(en_rsa3), 32'h3);
    chk("f_frz_rel",   32'(rst_rsa3), 32'h0);
    ena = 1'b1;
    tick(1);
    chk("f_resume_rel", 32'(rst_rsa3), 32'h0);
    tick(1);
    chk("f_release", 32'(rst_rsa3), 32'h3);
    gpio_stop = 1'b1; spi_stop = 1'b1;
    tick(1);
    gpio_stop = 1'b0; spi_stop = 1'b0;
    tick(2);

    // Reset asserted in the middle of WAIT_EOC
    run_mask = 2'b11; gpio_start = 1'b1;
    tick(1);
    gpio_start = 1'b0;
    tick(2);
    eoc_rsa_unit = 2'b01;
    tick(1);
    eoc_rsa_unit = 2'b00;
    chk("r_pre_done", 32'(done_mask), 32'h1);
    chk("r_pre_busy", 32'(busy), 32'h1);
    #2;
    rstb = 1'b0;
    #1;
    chk("r_en",    32'(en_rsa), 32'h0);
    chk("r_rel",   32'(rst_rsa), 32'h0);
    chk("r_busy",  32'(busy), 32'h0);
    chk("r_done",  32'(done_mask), 32'h0);
    chk("r_state", 32'(dut.state_q), 32'(RESET));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
